// File: rtl/apb_wr_master.sv
// APB3 write-only master: pulls {id, addr, data} requests from a FIFO, runs one
// SETUP/ACCESS transfer per request with a bounded wait, and returns an id/status response.
`timescale 1ns/1ps

module apb_wr_master #(
    parameter int ID_NUM      = 4,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                             ACLK_i,
    input  logic                             ARESETn_i,
    input  logic                             fifo_rvld_i,
    output logic                             fifo_rrdy_o,
    input  logic [ID_NUM+ADDR_W+DATA_W-1:0]  fifo_rpayload_i,
    output logic [ADDR_W-1:0]                PADDR_o,
    output logic                             PSEL_o,
    output logic                             PENABLE_o,
    output logic                             PWRITE_o,
    output logic [DATA_W-1:0]                PWDATA_o,
    output logic [DATA_W/8-1:0]              PSTRB_o,
    input  logic                             PREADY_i,
    input  logic                             PSLVERR_i,
    output logic                             rsp_vld_o,
    input  logic                             rsp_rdy_i,
    output logic [ID_NUM-1:0]                rsp_id_o,
    output logic                             rsp_err_o
);

    localparam int                PAY_W         = ID_NUM + ADDR_W + DATA_W;
    localparam logic [7:0]        WAIT_LAST     = 8'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LSB_MASK = ADDR_W'(2'd3);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                rrdy_q, rrdy_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                rsp_vld_q, rsp_vld_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ID_NUM-1:0]   id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          wait_cnt_q, wait_cnt_d;

    logic [ID_NUM-1:0]   pay_id_s;
    logic [ADDR_W-1:0]   pay_addr_s;
    logic [DATA_W-1:0]   pay_data_s;

    assign pay_id_s   = fifo_rpayload_i[PAY_W-1 -: ID_NUM];
    assign pay_addr_s = fifo_rpayload_i[DATA_W +: ADDR_W];
    assign pay_data_s = fifo_rpayload_i[DATA_W-1:0];

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        rrdy_d     = rrdy_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_err_d  = rsp_err_q;
        id_d       = id_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_rvld_i) begin
                    state_d   = ST_SETUP;
                    rrdy_d    = 1'b0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    rsp_err_d = 1'b0;
                    id_d      = pay_id_s;
                    addr_d    = pay_addr_s & ~ADDR_LSB_MASK;
                    data_d    = pay_data_s;
                end else begin
                    rrdy_d    = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d    = ST_ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = 8'd0;
            end
            ST_ACCESS: begin
                // A ready slave wins over the timeout on the final allowed cycle.
                if (PREADY_i) begin
                    state_d   = ST_RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rsp_vld_d = 1'b1;
                    rsp_err_d = PSLVERR_i;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = ST_RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rsp_vld_d = 1'b1;
                    rsp_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_rdy_i) begin
                    state_d   = ST_IDLE;
                    rsp_vld_d = 1'b0;
                    rrdy_d    = 1'b1;
                end else begin
                    rsp_vld_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                rrdy_d    = 1'b1;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                rsp_vld_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears the bus and drops any transfer in flight.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            state_q    <= ST_IDLE;
            rrdy_q     <= 1'b1;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            rrdy_q     <= rrdy_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Ready is gated by reset so it reads 0 during reset yet allows a handshake
    // on the very first edge after release.
    assign fifo_rrdy_o = rrdy_q & ARESETn_i;
    assign PADDR_o     = addr_q;
    assign PWDATA_o    = data_q;
    assign PSEL_o      = psel_q;
    assign PENABLE_o   = penable_q;
    assign PWRITE_o    = 1'b1;
    assign PSTRB_o     = {(DATA_W/8){1'b1}};
    assign rsp_vld_o   = rsp_vld_q;
    assign rsp_id_o    = id_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_wr_master.sv
// Randomized bench for apb_wr_master: a transaction-level plan yields both the
// per-cycle stimulus and the expected per-cycle outputs; one process compares them.
`timescale 1ns/1ps

module tb_apb_wr_master;

    localparam int ID_NUM  = 4;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int PAY_W   = ID_NUM + ADDR_W + DATA_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                fifo_rvld;
    logic                fifo_rrdy;
    logic [PAY_W-1:0]    fifo_pay;
    logic [ADDR_W-1:0]   paddr;
    logic                psel, penable, pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic                pready, pslverr;
    logic                rsp_vld, rsp_rdy, rsp_err;
    logic [ID_NUM-1:0]   rsp_id;

    always #5 clk = ~clk;

    apb_wr_master #(.ID_NUM(ID_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT)) dut (
        .ACLK_i(clk), .ARESETn_i(rst_n),
        .fifo_rvld_i(fifo_rvld), .fifo_rrdy_o(fifo_rrdy), .fifo_rpayload_i(fifo_pay),
        .PADDR_o(paddr), .PSEL_o(psel), .PENABLE_o(penable), .PWRITE_o(pwrite),
        .PWDATA_o(pwdata), .PSTRB_o(pstrb), .PREADY_i(pready), .PSLVERR_i(pslverr),
        .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_id_o(rsp_id), .rsp_err_o(rsp_err)
    );

    typedef struct packed {
        logic             rvld;
        logic [PAY_W-1:0] pay;
        logic             pready;
        logic             pslverr;
        logic             rsp_rdy;
    } stim_t;

    typedef struct packed {
        logic              rrdy;
        logic              psel;
        logic              pen;
        logic [ADDR_W-1:0] paddr;
        logic [DATA_W-1:0] pwdata;
        logic              rsp_vld;
        logic [ID_NUM-1:0] rsp_id;
        logic              rsp_err;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    exp_t  cur_e;
    int    errors = 0;
    int    checks = 0;
    int    cyc_idx = 0;
    bit    chk_en = 1'b0;

    int                acc_len_q[$];
    logic [ADDR_W-1:0] setup_addr_q[$];
    logic [DATA_W-1:0] setup_data_q[$];
    logic [ID_NUM:0]   rsp_q[$];
    int                run_len = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d t=%0t actual=%0h required=%0h", name, cyc_idx, $time, act, req);
        end
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.rvld    = 1'($urandom_range(0, 1));
        s.pay     = PAY_W'({$urandom(), $urandom()});
        s.pready  = 1'($urandom_range(0, 1));
        s.pslverr = 1'($urandom_range(0, 1));
        s.rsp_rdy = 1'($urandom_range(0, 1));
        return s;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.rrdy = 1'b1;
        return e;
    endfunction

    // One request: g idle cycles, handshake, SETUP, ACCESS cycles, then RESP with b stalled cycles.
    // w is the number of not-ready ACCESS cycles before ready; w >= TIMEOUT means the slave never answers.
    task automatic add_tx(input logic [ID_NUM-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input int g, input int w,
                          input bit slverr, input int b);
        stim_t s;
        exp_t  e;
        int    n;
        logic  err;
        n   = (w < TIMEOUT) ? w + 1 : TIMEOUT;
        err = (w < TIMEOUT) ? slverr : 1'b1;
        for (int i = 0; i < g; i++) begin
            s = rand_stim(); s.rvld = 1'b0;
            stim_q.push_back(s); exp_q.push_back(idle_exp());
        end
        s = rand_stim(); s.rvld = 1'b1; s.pay = {id, addr, data};
        stim_q.push_back(s); exp_q.push_back(idle_exp());
        e = '0; e.psel = 1'b1; e.paddr = {addr[ADDR_W-1:2], 2'b00}; e.pwdata = data;
        stim_q.push_back(rand_stim()); exp_q.push_back(e);
        e.pen = 1'b1;
        for (int k = 0; k < n; k++) begin
            s = rand_stim();
            s.pready = (w < TIMEOUT) && (k == w);
            if (s.pready) s.pslverr = slverr;
            stim_q.push_back(s); exp_q.push_back(e);
        end
        e = '0; e.rsp_vld = 1'b1; e.rsp_id = id; e.rsp_err = err;
        for (int j = 0; j <= b; j++) begin
            s = rand_stim(); s.rsp_rdy = (j == b);
            stim_q.push_back(s); exp_q.push_back(e);
        end
    endtask

    task automatic add_idle(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = rand_stim(); s.rvld = 1'b0;
            stim_q.push_back(s); exp_q.push_back(idle_exp());
        end
    endtask

    task automatic apply(input stim_t s);
        fifo_rvld = s.rvld; fifo_pay = s.pay; pready = s.pready;
        pslverr = s.pslverr; rsp_rdy = s.rsp_rdy;
    endtask

    task automatic apply_quiet();
        fifo_rvld = 1'b0; fifo_pay = '0; pready = 1'b0; pslverr = 1'b0; rsp_rdy = 1'b0;
    endtask

    task automatic run_timeline(input bit release_rst);
        for (int c = 0; c < stim_q.size(); c++) begin
            @(posedge clk); #1;
            if (c == 0 && release_rst) rst_n = 1'b1;
            apply(stim_q[c]);
            cyc_idx = c;
            chk_en  = 1'b1;
        end
        @(posedge clk); #1;
        chk_en = 1'b0;
        apply_quiet();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rrdy"},   fifo_rrdy, 1'b0);
        check({tag, "_psel"},   psel,      1'b0);
        check({tag, "_pen"},    penable,   1'b0);
        check({tag, "_paddr"},  paddr,     12'h000);
        check({tag, "_pwdata"}, pwdata,    32'h0);
        check({tag, "_rspvld"}, rsp_vld,   1'b0);
        check({tag, "_rspid"},  rsp_id,    4'h0);
        check({tag, "_rsperr"}, rsp_err,   1'b0);
        check({tag, "_pwrite"}, pwrite,    1'b1);
        check({tag, "_pstrb"},  pstrb,     4'hF);
    endtask

    // Cycle-by-cycle comparison against the planned expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            cur_e = exp_q[cyc_idx];
            check("rrdy",    fifo_rrdy, cur_e.rrdy);
            check("psel",    psel,      cur_e.psel);
            check("penable", penable,   cur_e.pen);
            check("rsp_vld", rsp_vld,   cur_e.rsp_vld);
            check("pwrite",  pwrite,    1'b1);
            check("pstrb",   pstrb,     4'hF);
            if (cur_e.psel) begin
                check("paddr",  paddr,  cur_e.paddr);
                check("pwdata", pwdata, cur_e.pwdata);
            end
            if (cur_e.rsp_vld) begin
                check("rsp_id",  rsp_id,  cur_e.rsp_id);
                check("rsp_err", rsp_err, cur_e.rsp_err);
            end
        end
    end

    // Records observed bus/response events for the literal spot checks.
    always @(negedge clk) begin
        if (chk_en) begin
            if (psel && !penable) begin
                setup_addr_q.push_back(paddr);
                setup_data_q.push_back(pwdata);
            end
            if (penable) begin
                run_len++;
            end else if (run_len > 0) begin
                acc_len_q.push_back(run_len);
                run_len = 0;
            end
            if (rsp_vld && rsp_rdy) rsp_q.push_back({rsp_id, rsp_err});
        end
    end

    initial begin
        bit found;
        int w;
        apply_quiet();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_checks("rst0");

        add_tx(4'h3, 12'h12E, 32'hDEADBEEF, 0, 0, 1'b0, 0);
        add_tx(4'h7, 12'h044, 32'h01234567, 1, 3, 1'b1, 0);
        add_tx(4'h9, 12'h3FF, 32'hCAFEF00D, 0, TIMEOUT, 1'b0, 1);
        add_tx(4'hA, 12'h100, 32'h11111111, 0, 0, 1'b0, 5);
        add_tx(4'h5, 12'h104, 32'h22222222, 0, 0, 1'b0, 0);
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 7))
                0:       w = TIMEOUT;
                1:       w = TIMEOUT - 1;
                default: w = $urandom_range(0, 4);
            endcase
            add_tx(ID_NUM'($urandom), ADDR_W'($urandom), $urandom(),
                   $urandom_range(0, 2), w, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        add_idle(3);
        run_timeline(1'b1);

        check("lit_ntx",    acc_len_q.size(), 45);
        check("lit_acc0",   acc_len_q[0], 1);
        check("lit_acc1",   acc_len_q[1], 4);
        check("lit_acc2",   acc_len_q[2], 16);
        check("lit_paddr0", setup_addr_q[0], 12'h12C);
        check("lit_wdata0", setup_data_q[0], 32'hDEADBEEF);
        check("lit_rsp0",   rsp_q[0], 5'h06);
        check("lit_rsp1",   rsp_q[1], 5'h0F);
        check("lit_rsp2",   rsp_q[2], 5'h13);
        check("lit_rsp3",   rsp_q[3], 5'h14);
        check("lit_rsp4",   rsp_q[4], 5'h0A);

        // Reset pulse in the middle of an ACCESS phase.
        @(posedge clk); #1;
        fifo_rvld = 1'b1; fifo_pay = {4'hE, 12'h0F0, 32'h0BADF00D}; pready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (penable) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_access", found, 1'b1);
        fifo_rvld = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_psel", psel,    1'b0);
        check("async_pen",  penable, 1'b0);
        check("async_rsp",  rsp_vld, 1'b0);
        reset_checks("rst1");
        repeat (2) @(posedge clk);

        stim_q.delete();
        exp_q.delete();
        add_tx(4'hC, 12'h2A6, 32'h5A5AA5A5, 2, 1, 1'b0, 1);
        add_idle(2);
        run_timeline(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
